// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out deframer: gathers WIDTH enabled bits into a word and
// hands each word downstream through a one-deep holding register.
module sipo_deframer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             serial_in,
  input  logic             frame_sync,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] parallel_out,
  output logic [WIDTH-1:0] shift_data,
  output logic [CNT_W-1:0] bit_count,
  output logic             overflow,
  input  logic             clear_overflow
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_next;
  logic             word_done;
  logic             accept;
  logic             drop;

  always_comb begin
    sreg_next = sreg;
    if (MSB_FIRST) sreg_next = {sreg[WIDTH-2:0], serial_in};
    else           sreg_next = {serial_in, sreg[WIDTH-1:1]};
  end

  // Handshake: a word transfers on any edge where out_valid and out_ready are
  // both high; a completed word may refill the holding register on that same
  // edge, otherwise it is dropped while the held word is still unconsumed.
  assign word_done = enable && !frame_sync && (bit_count == LAST_BIT);
  assign accept    = word_done && (!out_valid || out_ready);
  assign drop      = word_done && out_valid && !out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sreg      <= '0;
      bit_count <= '0;
    end else begin
      if (enable) begin
        sreg <= sreg_next;
        if (frame_sync)     bit_count <= CNT_W'(1);
        else if (word_done) bit_count <= '0;
        else                bit_count <= bit_count + CNT_W'(1);
      end else if (frame_sync) begin
        bit_count <= '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parallel_out <= '0;
      out_valid    <= 1'b0;
    end else if (accept) begin
      parallel_out <= sreg_next;
      out_valid    <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // A fresh drop outranks a clear requested on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)               overflow <= 1'b0;
    else if (drop)           overflow <= 1'b1;
    else if (clear_overflow) overflow <= 1'b0;
  end

  assign shift_data = sreg;

endmodule

// File: tb/tb_sipo_deframer.sv
// Bench for sipo_deframer: MSB-first and LSB-first instances share one stimulus
// stream and are checked every cycle against a bit-list model plus literals.
module tb_sipo_deframer;
  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0, serial_in = 1'b0, frame_sync = 1'b0;
  logic          out_ready = 1'b0, clear_overflow = 1'b0;
  logic          valid_m, valid_l, ovf_m, ovf_l;
  logic [W-1:0]  pout_m, pout_l, sd_m, sd_l;
  logic [CW-1:0] bc_m, bc_l;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(rst), .enable(enable), .serial_in(serial_in),
    .frame_sync(frame_sync), .out_ready(out_ready), .out_valid(valid_m),
    .parallel_out(pout_m), .shift_data(sd_m), .bit_count(bc_m),
    .overflow(ovf_m), .clear_overflow(clear_overflow));

  sipo_deframer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(rst), .enable(enable), .serial_in(serial_in),
    .frame_sync(frame_sync), .out_ready(out_ready), .out_valid(valid_l),
    .parallel_out(pout_l), .shift_data(sd_l), .bit_count(bc_l),
    .overflow(ovf_l), .clear_overflow(clear_overflow));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         hist[$];   // last W enabled bits, oldest first
  bit         cur[$];    // bits of the word in progress, first received first
  logic [W-1:0] m_held_m, m_held_l;
  bit         m_valid, m_ovf;

  function automatic logic [W-1:0] order(input bit q[$], input bit msb_first);
    logic [W-1:0] v = '0;
    for (int i = 0; i < q.size(); i++) begin
      if (msb_first) v[W-1-i] = q[i];
      else           v[i]     = q[i];
    end
    return v;
  endfunction

  task automatic model_step();
    bit done = 0;
    if (rst) begin
      hist = {};
      for (int i = 0; i < W; i++) hist.push_back(1'b0);
      cur = {};
      m_held_m = '0; m_held_l = '0; m_valid = 0; m_ovf = 0;
      return;
    end
    if (enable) begin
      hist.push_back(serial_in);
      void'(hist.pop_front());
      if (frame_sync) cur = {};
      cur.push_back(serial_in);
      if (!frame_sync && cur.size() == W) done = 1;
    end else if (frame_sync) begin
      cur = {};
    end
    if (done) begin
      if (!m_valid || out_ready) begin
        m_held_m = order(cur, 1'b1);
        m_held_l = order(cur, 1'b0);
        m_valid  = 1;
      end else begin
        m_ovf = 1;
      end
      cur = {};
    end else begin
      if (m_valid && out_ready) m_valid = 0;
      if (clear_overflow) m_ovf = 0;
    end
    if (done && clear_overflow && (!m_valid || out_ready)) m_ovf = 0;
  endtask

  // Compare process: every cycle, shortly after the active edge.
  always @(posedge clk) begin
    model_step();
    #1;
    check("valid_m", 64'(valid_m), 64'(m_valid));
    check("valid_l", 64'(valid_l), 64'(m_valid));
    check("pout_m",  64'(pout_m),  64'(m_held_m));
    check("pout_l",  64'(pout_l),  64'(m_held_l));
    check("shift_m", 64'(sd_m),    64'(order(hist, 1'b1)));
    check("shift_l", 64'(sd_l),    64'(order(hist, 1'b0)));
    check("count_m", 64'(bc_m),    64'(cur.size()));
    check("count_l", 64'(bc_l),    64'(cur.size()));
    check("ovf_m",   64'(ovf_m),   64'(m_ovf));
    check("ovf_l",   64'(ovf_l),   64'(m_ovf));
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic en, input logic b, input logic fs);
    @(negedge clk);
    enable = en; serial_in = b; frame_sync = fs;
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) drive(1'b1, v[i], 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0);
    settle();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] v;
    settle();
    check("rst_valid", 64'(valid_m), 64'd0);
    check("rst_pout",  64'(pout_m),  64'd0);
    check("rst_count", 64'(bc_m),    64'd0);
    check("rst_ovf",   64'(ovf_m),   64'd0);
    @(negedge clk);
    rst = 1'b0;

    // A5 palindrome, then C0/03 bit-order check
    out_ready = 1'b1;
    send_byte(8'hA5);
    settle();
    check("a5_valid", 64'(valid_m), 64'd1);
    check("a5_pout_m", 64'(pout_m), 64'hA5);
    check("a5_pout_l", 64'(pout_l), 64'hA5);
    check("a5_count", 64'(bc_m), 64'd0);
    idle();
    check("a5_pulse_end", 64'(valid_m), 64'd0);

    send_byte(8'hC0);
    settle();
    check("c0_pout_m", 64'(pout_m), 64'hC0);
    check("c0_pout_l", 64'(pout_l), 64'h03);
    idle();

    // enable gaps: count holds, word completes only on 8th enabled edge
    v = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      drive(1'b1, v[i], 1'b0);
      if (i != 0) begin
        drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        if (i == 4) begin
          settle();
          check("gap_count", 64'(bc_m), 64'd4);
          check("gap_valid", 64'(valid_m), 64'd0);
        end
      end
    end
    settle();
    check("3c_pout_m", 64'(pout_m), 64'h3C);
    check("3c_valid", 64'(valid_m), 64'd1);
    idle();

    // overflow: second word dropped; drop beats a same-edge clear
    out_ready = 1'b0;
    send_byte(8'h11);
    settle();
    check("ovf_first", 64'(pout_m), 64'h11);
    v = 8'h22;
    for (int i = 7; i >= 1; i--) drive(1'b1, v[i], 1'b0);
    drive(1'b1, v[0], 1'b0);
    clear_overflow = 1'b1;
    settle();
    clear_overflow = 1'b0;
    check("ovf_flag", 64'(ovf_m), 64'd1);
    check("ovf_hold", 64'(pout_m), 64'h11);
    check("ovf_hold_l", 64'(pout_l), 64'h88);
    check("ovf_valid", 64'(valid_m), 64'd1);
    drive(1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;
    settle();
    check("drain_valid", 64'(valid_m), 64'd0);
    check("drain_pout", 64'(pout_m), 64'h11);
    check("drain_ovf", 64'(ovf_m), 64'd1);
    out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    clear_overflow = 1'b1;
    settle();
    clear_overflow = 1'b0;
    check("ovf_clear", 64'(ovf_m), 64'd0);

    // drain and fill on the same edge
    send_byte(8'hF0);
    settle();
    check("f0_pout", 64'(pout_m), 64'hF0);
    v = 8'h0F;
    for (int i = 7; i >= 1; i--) drive(1'b1, v[i], 1'b0);
    drive(1'b1, v[0], 1'b0);
    out_ready = 1'b1;
    settle();
    check("refill_pout", 64'(pout_m), 64'h0F);
    check("refill_valid", 64'(valid_m), 64'd1);
    check("refill_ovf", 64'(ovf_m), 64'd0);
    idle();

    // frame_sync realigns; enable=0 sync zeroes the count
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    settle();
    check("sync_idle_count", 64'(bc_m), 64'd0);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    settle();
    check("sync_count", 64'(bc_m), 64'd1);
    v = 8'h96;
    for (int i = 6; i >= 0; i--) drive(1'b1, v[i], 1'b0);
    settle();
    check("sync_pout_m", 64'(pout_m), 64'h96);
    check("sync_pout_l", 64'(pout_l), 64'h69);

    // reset mid-word while a word is held
    drive(1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    send_byte(8'h5A);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0);
    settle();
    check("pre_rst_count", 64'(bc_m), 64'd3);
    check("pre_rst_valid", 64'(valid_m), 64'd1);
    @(negedge clk);
    rst = 1'b1; enable = 1'b0;
    #1;
    check("async_valid", 64'(valid_m), 64'd0);
    check("async_pout", 64'(pout_m), 64'd0);
    check("async_count", 64'(bc_m), 64'd0);
    check("async_shift", 64'(sd_m), 64'd0);
    settle();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send_byte(8'h81);
    settle();
    check("post_rst_pout", 64'(pout_m), 64'h81);
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
